// File: rtl/serial_deserializer.sv
// Serial-to-parallel front end for the 8-entry queue: assembles MSB-first words and
// offers each one with a one-cycle pulse until acked. Optional parity: DESERIALIZER_PARITY_EN.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock_10k,
    input  logic             reset,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_ready,
    output logic             status_out,
    output logic             overrun_out,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH+1) + 1;
`ifdef DESERIALIZER_PARITY_EN
    localparam int LAST = WIDTH;
    localparam int SW   = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
    // The final data bit goes straight from data_in into the word, so the
    // shifter only has to hold the WIDTH-1 bits that came before it.
    localparam int SW   = WIDTH - 1;
`endif

    typedef enum logic [1:0] {RECEIVE, OFFER, WAIT_ACK} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_status;
    logic             r_overrun;
    logic             w_last;
    logic             w_frame_ok;
    logic [WIDTH-1:0] w_word;

    assign w_last = write_in && (r_cnt == CW'(LAST));

`ifdef DESERIALIZER_PARITY_EN
    logic r_perr;
    // Even parity over data plus parity bit; the parity bit never enters the shifter.
    assign w_frame_ok = ~(^r_shift ^ data_in);
    assign w_word     = r_shift;
    assign parity_err = r_perr;

    always_ff @(posedge clock_10k or negedge reset) begin
        if (!reset)
            r_perr <= 1'b0;
        else
            r_perr <= (r_state == RECEIVE) && w_last && !w_frame_ok;
    end
`else
    assign w_frame_ok = 1'b1;
    assign w_word     = {r_shift, data_in};
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clock_10k or negedge reset) begin
        if (!reset)
            r_state <= RECEIVE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RECEIVE:  if (w_last && w_frame_ok) w_next = OFFER;
            OFFER:    w_next = WAIT_ACK;
            WAIT_ACK: w_next = ack_in ? RECEIVE : OFFER;
            default:  w_next = RECEIVE;
        endcase
    end

    always_ff @(posedge clock_10k or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_status  <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= write_in && (r_state != RECEIVE);
            case (r_state)
                RECEIVE: begin
                    if (write_in) begin
`ifdef DESERIALIZER_PARITY_EN
                        if (!w_last) r_shift <= {r_shift[SW-2:0], data_in};
`else
                        r_shift <= {r_shift[SW-2:0], data_in};
`endif
                        if (w_last) begin
                            r_cnt <= '0;
                            if (w_frame_ok) begin
                                r_data   <= w_word;
                                r_status <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                WAIT_ACK: if (ack_in) r_status <= 1'b1;
                default: ;
            endcase
        end
    end

    assign data_out    = r_data;
    assign data_ready  = (r_state == OFFER);
    assign status_out  = r_status;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: per-cycle frame-level model plus directed literal checks,
// with a small behavioural 8-deep queue that produces registered acks.
module tb_serial_deserializer;

    localparam int W = 8;
`ifdef DESERIALIZER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clock_10k = 1'b0;
    logic         reset     = 1'b0;
    logic         data_in   = 1'b0;
    logic         write_in  = 1'b0;
    logic         man_ack   = 1'b0;
    logic         q_ack     = 1'b0;
    logic         q_en      = 1'b0;
    logic         ack_in;
    logic [W-1:0] data_out;
    logic         data_ready, status_out, overrun_out, parity_err;

    assign ack_in = q_en ? q_ack : man_ack;

    always #5 clock_10k = ~clock_10k;

    serial_deserializer #(.WIDTH(W)) dut (
        .clock_10k  (clock_10k),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .ack_in     (ack_in),
        .data_out   (data_out),
        .data_ready (data_ready),
        .status_out (status_out),
        .overrun_out(overrun_out),
        .parity_err (parity_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a word is either being collected or pending; a pending
    // word alternates offer / wait cycles until an ack lands in a wait cycle.
    bit           m_bits[$];
    logic [W-1:0] m_word, m_tmp;
    bit           m_pending, m_offer, m_over, m_perr;
    int           m_ones;

    always @(posedge clock_10k) begin
        if (!reset) begin
            m_bits.delete();
            m_word = '0; m_pending = 0; m_offer = 0; m_over = 0; m_perr = 0;
        end else begin
            m_over = write_in && m_pending;
            m_perr = 0;
            if (!m_pending) begin
                if (write_in) begin
                    m_bits.push_back(data_in);
                    if (m_bits.size() == FRAME) begin
                        m_ones = 0;
                        m_tmp  = '0;
                        foreach (m_bits[i]) m_ones += int'(m_bits[i]);
                        for (int i = 0; i < W; i++) m_tmp = {m_tmp[W-2:0], m_bits[i]};
                        if (FRAME == W || m_ones % 2 == 0) begin
                            m_word = m_tmp; m_pending = 1; m_offer = 1;
                        end else begin
                            m_perr = 1;
                        end
                        m_bits.delete();
                    end
                end
            end else if (m_offer) begin
                m_offer = 0;
            end else if (ack_in) begin
                m_pending = 0;
            end else begin
                m_offer = 1;
            end
        end
        #2;
        check("data_out",    32'(data_out),    32'(m_word));
        check("data_ready",  32'(data_ready),  32'(m_pending && m_offer));
        check("status_out",  32'(status_out),  32'(!m_pending));
        check("overrun_out", 32'(overrun_out), 32'(m_over));
        check("parity_err",  32'(parity_err),  32'(m_perr));
    end

    // Behavioural 8-deep queue: enqueue on an offer it can take, ack one cycle later.
    logic [W-1:0] qm[$];
    bit           push_flag = 0;
    bit           deq_req   = 0;

    always @(negedge clock_10k) begin
        if (q_en) begin
            if (deq_req && qm.size() > 0) begin
                void'(qm.pop_front());
                deq_req = 0;
            end
            q_ack     = push_flag;
            push_flag = data_ready && qm.size() < 8;
            if (push_flag) qm.push_back(data_out);
        end else begin
            q_ack     = 0;
            push_flag = 0;
        end
    end

    task automatic wait_receive();
        int t = 0;
        while (!status_out && t < 60) begin @(negedge clock_10k); t++; end
        check("wait_receive_timeout", 32'(status_out), 32'd1);
    endtask

    task automatic send_bits(input logic [FRAME-1:0] f);
        wait_receive();
        for (int i = FRAME-1; i >= 0; i--) begin
            data_in = f[i]; write_in = 1'b1;
            @(negedge clock_10k);
        end
        write_in = 1'b0; data_in = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
`ifdef DESERIALIZER_PARITY_EN
        send_bits({w, ^w});
`else
        send_bits(w);
`endif
    endtask

    task automatic ack_word();
        int t = 0;
        man_ack = 1'b1;
        @(negedge clock_10k);
        while (!status_out && t < 20) begin @(negedge clock_10k); t++; end
        man_ack = 1'b0;
        check("ack_timeout", 32'(status_out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    int pulses;

    initial begin
        repeat (3) @(negedge clock_10k);
        check("rst_data_out",   32'(data_out),    32'h0);
        check("rst_data_ready", 32'(data_ready),  32'h0);
        check("rst_status",     32'(status_out),  32'h1);
        check("rst_overrun",    32'(overrun_out), 32'h0);
        check("rst_parity_err", 32'(parity_err),  32'h0);
        reset = 1'b1;
        @(negedge clock_10k);

        // Basic word, acked in the first wait cycle
        send_word(8'hA5);
        check("a5_data",   32'(data_out),   32'hA5);
        check("a5_ready",  32'(data_ready), 32'h1);
        check("a5_status", 32'(status_out), 32'h0);
        @(negedge clock_10k);
        check("a5_ready_once", 32'(data_ready), 32'h0);
        man_ack = 1'b1;
        @(negedge clock_10k);
        man_ack = 1'b0;
        check("a5_status_back", 32'(status_out), 32'h1);

        // Retry every second cycle while no ack arrives
        send_word(8'h3C);
        pulses = 0;
        repeat (10) begin
            pulses += int'(data_ready);
            @(negedge clock_10k);
        end
        check("3c_pulses", 32'(pulses), 32'd5);
        check("3c_data",   32'(data_out), 32'h3C);
        ack_word();
        pulses = 0;
        repeat (6) begin
            pulses += int'(data_ready);
            @(negedge clock_10k);
        end
        check("3c_no_pulse_after_ack", 32'(pulses), 32'd0);

        // Bit presented while waiting for an ack is dropped
        send_word(8'h5A);
        @(negedge clock_10k);
        data_in = 1'b1; write_in = 1'b1;
        @(negedge clock_10k);
        write_in = 1'b0; data_in = 1'b0;
        check("overrun_pulse", 32'(overrun_out), 32'h1);
        @(negedge clock_10k);
        check("overrun_once", 32'(overrun_out), 32'h0);
        ack_word();
        send_word(8'h69);
        check("after_overrun_data", 32'(data_out), 32'h69);
        ack_word();

        // Reset mid-frame discards the partial word
        wait_receive();
        for (int i = 0; i < 4; i++) begin
            data_in = 1'b1; write_in = 1'b1;
            @(negedge clock_10k);
        end
        write_in = 1'b0; data_in = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_data",   32'(data_out),   32'h0);
        check("midrst_status", 32'(status_out), 32'h1);
        check("midrst_ready",  32'(data_ready), 32'h0);
        repeat (2) @(negedge clock_10k);
        reset = 1'b1;
        @(negedge clock_10k);
        send_word(8'hF0);
        check("f0_data", 32'(data_out), 32'hF0);
        ack_word();

`ifdef DESERIALIZER_PARITY_EN
        send_bits({8'hA5, 1'b0});
        check("par_ok_ready", 32'(data_ready), 32'h1);
        check("par_ok_data",  32'(data_out),   32'hA5);
        ack_word();
        send_bits({8'hA5, 1'b1});
        check("par_bad_err",   32'(parity_err), 32'h1);
        check("par_bad_ready", 32'(data_ready), 32'h0);
        check("par_bad_data",  32'(data_out),   32'hA5);
        send_bits({8'hC3, 1'b1});
        check("par_bad2_err",  32'(parity_err), 32'h1);
        check("par_bad2_data", 32'(data_out),   32'hA5);
        @(negedge clock_10k);
        check("par_err_once",  32'(parity_err), 32'h0);
`endif

        // Nine words into an 8-deep queue with no dequeue
        q_en = 1'b1;
        for (int k = 1; k <= 9; k++) send_word(W'(k));
        repeat (20) @(negedge clock_10k);
        check("q_full_len",    32'(qm.size()),  32'd8);
        check("q_full_status", 32'(status_out), 32'h0);
        check("q_full_data",   32'(data_out),   32'h09);
        check("q_head",        32'(qm[0]),      32'h01);
        check("q_tail",        32'(qm[7]),      32'h08);
        deq_req = 1;
        wait_receive();
        check("q_after_deq_len",  32'(qm.size()), 32'd8);
        check("q_after_deq_head", 32'(qm[0]),     32'h02);
        check("q_after_deq_tail", 32'(qm[7]),     32'h09);
        q_en = 1'b0;
        repeat (3) @(negedge clock_10k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
